multiplier_arbiter: RTL and testbench
=====================================

# multiplier_arbiter

Shares one `multiplier` instance (start/ready handshake, N-bit operands, 2N-bit product) between R independent requesters. Picks one pending requester by round-robin, captures its operands, sequences the multiplier, and returns the product with a one-hot completion pulse. Sits between client blocks and the single multiplier, which keeps its existing start/ready contract.

## Interface
- `N`, 4: operand width in bits. Must match the attached multiplier.
- `R`, 4: number of requesters, R ≥ 2.

- `clock`  in  1  sole clock; all state updates on the rising edge.
- `n_reset`  in  1  asynchronous active-low reset.
- `req`  in  R  per-requester request level; held until granted.
- `req_multiplicand`  in  R*N  packed operands; requester i occupies bits [i*N +: N].
- `req_multiplier`  in  R*N  packed operands, same layout.
- `grant`  out  R  one-hot, single-cycle; operands of that requester have been captured.
- `done`  out  R  one-hot, single-cycle; `product` is valid for that requester.
- `product`  out  2N  last result; holds until the next `done`.
- `busy`  out  1  high while a multiplication is outstanding.
- `mul_start`  out  1  start pulse to the multiplier.
- `mul_ready`  in  1  multiplier idle and result valid.
- `mul_multiplicand`  out  N  captured operand, stable while busy.
- `mul_multiplier`  out  N  captured operand, stable while busy.
- `mul_product`  in  2N  multiplier result.

## Operation
- Multiplier contract: `mul_start` is sampled only when `mul_ready`=1. `mul_ready` is low from the edge after acceptance until the product is valid.
- States are `ARB_IDLE` and `ARB_RUN`.
- In ARB_IDLE with `req`≠0 at an edge, the arbiter:
  - selects the winner: the first set bit scanning upward from `last+1`, wrapping modulo R;
  - latches the winner's operands into `mul_*` and records `owner`;
  - registers `grant`=onehot(owner) and `mul_start`=1;
  - moves to ARB_RUN.
- In ARB_IDLE with `req`=0, nothing changes.
- In ARB_RUN, the completion condition is `mul_ready`=1 and `mul_start`=0. This condition masks any stale ready during the start cycle. At the first edge where it holds, the arbiter:
  - latches `mul_product` into `product`;
  - registers `done`=onehot(owner);
  - sets `last`=owner;
  - returns to ARB_IDLE.
- `req` is ignored in ARB_RUN. A requester still asserting `req` when the arbiter re-enters ARB_IDLE starts a new request.
- `req` and `grant` for the same requester in the same cycle is legal; the requester drops `req` on seeing `grant`.
- `busy` = (state == ARB_RUN).
- All registered outputs are zero-extended; no arithmetic is performed in this block.

## Timing
- Reset (asynchronous, any state, including mid-ARB_RUN):
  - state → ARB_IDLE;
  - `grant`, `done`, `mul_start`, `busy` → 0;
  - `product`, `mul_multiplicand`, `mul_multiplier` → 0;
  - `last` → R-1, so requester 0 has first priority.
- The multiplier shares `n_reset`, so no operation survives reset.
- Edge E0 samples `req` in ARB_IDLE. The cycle after E0 has `grant` and `mul_start` high. The multiplier accepts at E1.
- With multiplier latency L (edges from acceptance until `mul_ready` is high), the product is captured at E1+L. `done` is high in the following cycle.
- Request-to-done latency is L+2 cycles.
- At least one ARB_IDLE cycle separates `done` from the next `grant`. Sustained throughput is one result per L+2 cycles.
- `grant` and `done` are never high together.

## Structure
- Package `multiplier_pkg` holds `arb_state_t` (enum ARB_IDLE, ARB_RUN) and a `onehot` helper function.
- Sub-module `multiplier_rr_picker` is purely combinational.
  - Inputs: `req[R-1:0]`, `last[$clog2(R)-1:0]`.
  - Outputs: `valid`, `pick`.
  - Reused by future shared-resource arbiters.
- The top instantiates the picker, the state register and the capture registers. It does not instantiate the multiplier; integration wires `mul_*` to it.

## Test plan
Benches use N=4, R=4 and the real `multiplier`.
- Single request: `req`=0010, operands 7,9 → `grant`=0010 for 1 cycle, then `done`=0010 after L+1 further cycles with `product`=63; `busy` falls with `done`.
- Simultaneous requests: `req`=1111 held after reset, each dropped on its grant, operands i+1 and 3 → service order 0,1,2,3, products 3,6,9,12; `done` order matches `grant` order.
- Wrap and fairness: `last`=1, `req`=1001 → requester 3 served, then 0. Requester 2 raising `req` during ARB_RUN is not granted before ARB_IDLE.
- Extreme operands: 15×15 → `product`=225. 0×13 → 0. `product` holds after `done` until the next completion.
- Stale ready: a multiplier model holding `mul_ready`=1 for one cycle after `mul_start` → no early `done`; completion occurs only on a later ready.
- Reset mid-operation: assert `n_reset`=0 while in ARB_RUN → all outputs 0 immediately. After release, with `req`=1111, requester 0 is granted first.

Source files
------------

// File: rtl/multiplier_pkg.sv
// Shared types and helpers for the multiplier arbiter slice.
//   arb_state_t : arbiter FSM states (idle / multiplication outstanding)
//   onehot()    : index to one-hot vector, truncated by the caller to R bits
package multiplier_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_RUN  = 1'b1
  } arb_state_t;

  localparam int ONEHOT_W = 32;

  function automatic logic [ONEHOT_W-1:0] onehot(input logic [ONEHOT_W-1:0] idx);
    return ONEHOT_W'(1) << idx;
  endfunction

endpackage

// File: rtl/multiplier_rr_picker.sv
// Combinational round-robin picker.
//   req   : pending request levels, one bit per requester
//   last  : index of the most recently served requester
//   valid : at least one request pending
//   pick  : first set bit of req scanning upward from last+1, wrapping modulo R
module multiplier_rr_picker #(
  parameter  int R  = 4,
  localparam int LW = (R > 1) ? $clog2(R) : 1
) (
  input  logic [R-1:0]  req,
  input  logic [LW-1:0] last,
  output logic          valid,
  output logic [LW-1:0] pick
);

  logic [LW-1:0] idx;

  // Scan from the farthest candidate down to last+1 so the nearest hit wins.
  always_comb begin
    valid = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = R; k >= 1; k--) begin
      idx = LW'((int'(last) + k) % R);
      if (req[idx]) begin
        valid = 1'b1;
        pick  = idx;
      end
    end
  end

endmodule

// File: rtl/multiplier_arbiter.sv
// Round-robin front end sharing one start/ready multiplier among R requesters.
//   clock, n_reset        : clock, asynchronous active-low reset
//   req                   : per-requester request levels
//   req_multiplicand/_multiplier : packed operands, requester i at [i*N +: N]
//   grant / done          : one-hot single-cycle capture / completion pulses
//   product               : last result, held until the next done
//   busy                  : multiplication outstanding
//   mul_start/mul_ready/mul_multiplicand/mul_multiplier/mul_product : multiplier side
module multiplier_arbiter
  import multiplier_pkg::*;
#(
  parameter int N = 4,
  parameter int R = 4
) (
  input  logic           clock,
  input  logic           n_reset,
  input  logic [R-1:0]   req,
  input  logic [R*N-1:0] req_multiplicand,
  input  logic [R*N-1:0] req_multiplier,
  output logic [R-1:0]   grant,
  output logic [R-1:0]   done,
  output logic [2*N-1:0] product,
  output logic           busy,
  output logic           mul_start,
  input  logic           mul_ready,
  output logic [N-1:0]   mul_multiplicand,
  output logic [N-1:0]   mul_multiplier,
  input  logic [2*N-1:0] mul_product
);

  localparam int LW = (R > 1) ? $clog2(R) : 1;

  arb_state_t           state_q, state_d;
  logic [LW-1:0]        owner_q;
  logic [LW-1:0]        last_q;
  logic [LW-1:0]        pick;
  logic                 pick_valid;
  logic                 start_run;
  logic                 finish_run;
  logic [ONEHOT_W-1:0]  pick_oh;
  logic [ONEHOT_W-1:0]  owner_oh;

  multiplier_rr_picker #(.R(R)) u_picker (
    .req   (req),
    .last  (last_q),
    .valid (pick_valid),
    .pick  (pick)
  );

  assign pick_oh  = onehot(ONEHOT_W'(pick));
  assign owner_oh = onehot(ONEHOT_W'(owner_q));
  assign busy     = (state_q == ARB_RUN);

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) state_q <= ARB_IDLE;
    else          state_q <= state_d;
  end

  // mul_start is still high in the first RUN cycle, and the multiplier may still
  // show ready from its idle state then; gating on !mul_start ignores that ready.
  always_comb begin
    state_d    = state_q;
    start_run  = 1'b0;
    finish_run = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          start_run = 1'b1;
          state_d   = ARB_RUN;
        end
      end
      ARB_RUN: begin
        if (mul_ready && !mul_start) begin
          finish_run = 1'b1;
          state_d    = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Capture stage: operands on start, product on completion.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      grant            <= '0;
      done             <= '0;
      mul_start        <= 1'b0;
      owner_q          <= '0;
      last_q           <= LW'(R - 1);
      product          <= '0;
      mul_multiplicand <= '0;
      mul_multiplier   <= '0;
    end else begin
      grant     <= '0;
      done      <= '0;
      mul_start <= 1'b0;
      if (start_run) begin
        owner_q          <= pick;
        grant            <= pick_oh[R-1:0];
        mul_start        <= 1'b1;
        mul_multiplicand <= req_multiplicand[int'(pick)*N +: N];
        mul_multiplier   <= req_multiplier[int'(pick)*N +: N];
      end
      if (finish_run) begin
        product <= mul_product;
        done    <= owner_oh[R-1:0];
        last_q  <= owner_q;
      end
    end
  end

endmodule

// File: tb/tb_multiplier_arbiter.sv
module tb_multiplier_arbiter;

  localparam int N = 4;
  localparam int R = 4;
  localparam int L = 3;

  logic           clock = 1'b0;
  logic           n_reset;
  logic [R-1:0]   req;
  logic [R*N-1:0] mc, mp;
  logic [R-1:0]   grant, done;
  logic [2*N-1:0] product;
  logic           busy, mul_start, mul_ready;
  logic [N-1:0]   mul_multiplicand, mul_multiplier;
  logic [2*N-1:0] mul_product;

  always #5 clock = ~clock;

  multiplier_arbiter #(.N(N), .R(R)) dut (
    .clock            (clock),
    .n_reset          (n_reset),
    .req              (req),
    .req_multiplicand (mc),
    .req_multiplier   (mp),
    .grant            (grant),
    .done             (done),
    .product          (product),
    .busy             (busy),
    .mul_start        (mul_start),
    .mul_ready        (mul_ready),
    .mul_multiplicand (mul_multiplicand),
    .mul_multiplier   (mul_multiplier),
    .mul_product      (mul_product)
  );

  // Behavioural multiplier: ready is sampled high L edges after acceptance.
  // In stale mode the product bus shows garbage until the real result lands.
  logic [2*N-1:0] m_a, m_b;
  int             m_cnt;
  logic           stale;

  always @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      mul_ready   <= 1'b1;
      mul_product <= '0;
      m_cnt       <= 0;
      m_a         <= '0;
      m_b         <= '0;
    end else if (mul_ready && mul_start) begin
      mul_ready <= 1'b0;
      m_a       <= (2*N)'(mul_multiplicand);
      m_b       <= (2*N)'(mul_multiplier);
      m_cnt     <= L - 1;
      if (stale) mul_product <= 8'hEE;
    end else if (!mul_ready) begin
      if (m_cnt == 1) begin
        mul_ready   <= 1'b1;
        mul_product <= m_a * m_b;
      end
      m_cnt <= m_cnt - 1;
    end
  end

  typedef struct packed {
    logic [R-1:0] oh;
    logic [N-1:0] a;
    logic [N-1:0] b;
  } gexp_t;

  typedef struct packed {
    logic [R-1:0]   oh;
    logic [2*N-1:0] p;
  } dexp_t;

  gexp_t gq[$];
  dexp_t dq[$];
  gexp_t ge;
  dexp_t de;
  int    checks = 0;
  int    errors = 0;

  task automatic expect_grant(input int i);
    gexp_t g;
    g.oh = R'(1) << i;
    g.a  = mc[i*N +: N];
    g.b  = mp[i*N +: N];
    gq.push_back(g);
  endtask

  task automatic expect_req(input int i);
    dexp_t d;
    logic [2*N-1:0] a, b;
    expect_grant(i);
    a    = (2*N)'(mc[i*N +: N]);
    b    = (2*N)'(mp[i*N +: N]);
    d.oh = R'(1) << i;
    d.p  = a * b;
    dq.push_back(d);
  endtask

  // Scoreboard: grants and completions popped in order as the DUT produces them.
  always @(negedge clock) begin
    if (|grant) begin
      checks++;
      if (gq.size() == 0) begin
        errors++;
        $display("FAIL grant_unexpected got=%b", grant);
      end else begin
        ge = gq.pop_front();
        if (grant !== ge.oh || mul_multiplicand !== ge.a || mul_multiplier !== ge.b ||
            mul_start !== 1'b1 || busy !== 1'b1) begin
          errors++;
          $display("FAIL grant got=%b a=%0d b=%0d start=%b busy=%b want=%b a=%0d b=%0d start=1 busy=1",
                   grant, mul_multiplicand, mul_multiplier, mul_start, busy, ge.oh, ge.a, ge.b);
        end
      end
    end
    if (|done) begin
      checks++;
      if (dq.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected got=%b product=%0d", done, product);
      end else begin
        de = dq.pop_front();
        if (done !== de.oh || product !== de.p || busy !== 1'b0) begin
          errors++;
          $display("FAIL done got=%b product=%0d busy=%b want=%b product=%0d busy=0",
                   done, product, busy, de.oh, de.p);
        end
      end
    end
    if (|grant && |done) begin
      checks++;
      errors++;
      $display("FAIL grant_done_overlap grant=%b done=%b", grant, done);
    end
  end

  task automatic wait_drained(input string tag);
    int n = 0;
    while ((gq.size() != 0 || dq.size() != 0 || busy || req != 0) && n < 200) begin
      @(negedge clock);
      req = req & ~grant;
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL %s timeout pending_grants=%0d pending_dones=%0d required=0", tag, gq.size(), dq.size());
    end
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if (grant !== '0 || done !== '0 || mul_start !== 1'b0 || busy !== 1'b0 ||
        product !== '0 || mul_multiplicand !== '0 || mul_multiplier !== '0) begin
      errors++;
      $display("FAIL %s got grant=%b done=%b start=%b busy=%b product=%0d a=%0d b=%0d required all 0",
               tag, grant, done, mul_start, busy, product, mul_multiplicand, mul_multiplier);
    end
  endtask

  task automatic test_reset();
    n_reset = 1'b0;
    req     = '0;
    mc      = '0;
    mp      = '0;
    stale   = 1'b0;
    repeat (2) @(negedge clock);
    check_all_zero("reset_asserted");
    n_reset = 1'b1;
    repeat (2) @(negedge clock);
    check_all_zero("reset_idle");
  endtask

  task automatic test_single();
    int k;
    mc[1*N +: N] = 4'd7;
    mp[1*N +: N] = 4'd9;
    expect_req(1);
    req = 4'b0010;
    @(negedge clock);
    checks++;
    if (grant !== 4'b0010 || mul_start !== 1'b1) begin
      errors++;
      $display("FAIL single_grant got=%b start=%b want=0010 start=1", grant, mul_start);
    end
    req = '0;
    k = 0;
    while (done === '0 && k < 20) begin
      @(negedge clock);
      k++;
    end
    checks++;
    if (k != L + 1 || product !== 8'd63 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_latency got=%0d product=%0d busy=%b want=%0d product=63 busy=0",
               k, product, busy, L + 1);
    end
    wait_drained("single");
  endtask

  task automatic test_simultaneous();
    n_reset = 1'b0;
    @(negedge clock);
    for (int i = 0; i < R; i++) begin
      mc[i*N +: N] = N'(i + 1);
      mp[i*N +: N] = 4'd3;
    end
    for (int i = 0; i < R; i++) expect_req(i);
    req     = 4'b1111;
    n_reset = 1'b1;
    wait_drained("simultaneous");
  endtask

  task automatic test_wrap();
    mc[1*N +: N] = 4'd2;
    mp[1*N +: N] = 4'd2;
    expect_req(1);
    req = 4'b0010;
    wait_drained("wrap_setup");
    mc[3*N +: N] = 4'd11; mp[3*N +: N] = 4'd5;
    mc[0*N +: N] = 4'd6;  mp[0*N +: N] = 4'd7;
    mc[2*N +: N] = 4'd9;  mp[2*N +: N] = 4'd8;
    expect_req(3);
    expect_req(0);
    expect_req(2);
    req = 4'b1001;
    @(negedge clock);
    req = req & ~grant;
    @(negedge clock);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL wrap_busy got=%b want=1", busy);
    end
    req[2] = 1'b1;
    wait_drained("wrap");
  endtask

  task automatic test_extreme();
    mc[0*N +: N] = 4'd15; mp[0*N +: N] = 4'd15;
    mc[1*N +: N] = 4'd0;  mp[1*N +: N] = 4'd13;
    expect_req(0);
    req = 4'b0001;
    wait_drained("extreme_max");
    repeat (3) @(negedge clock);
    checks++;
    if (product !== 8'd225) begin
      errors++;
      $display("FAIL product_hold got=%0d want=225", product);
    end
    expect_req(1);
    req = 4'b0010;
    wait_drained("extreme_zero");
    checks++;
    if (product !== 8'd0) begin
      errors++;
      $display("FAIL product_zero got=%0d want=0", product);
    end
  endtask

  task automatic test_stale_ready();
    int k;
    stale = 1'b1;
    mc[2*N +: N] = 4'd5;
    mp[2*N +: N] = 4'd6;
    expect_req(2);
    req = 4'b0100;
    @(negedge clock);
    req = '0;
    checks++;
    if (mul_ready !== 1'b1 || mul_start !== 1'b1) begin
      errors++;
      $display("FAIL stale_setup got ready=%b start=%b want ready=1 start=1", mul_ready, mul_start);
    end
    k = 0;
    while (done === '0 && k < 20) begin
      @(negedge clock);
      k++;
    end
    checks++;
    if (k != L + 1 || product !== 8'd30) begin
      errors++;
      $display("FAIL stale_latency got=%0d product=%0d want=%0d product=30", k, product, L + 1);
    end
    wait_drained("stale");
    stale = 1'b0;
  endtask

  task automatic test_reset_mid();
    mc[0*N +: N] = 4'd4;
    mp[0*N +: N] = 4'd4;
    expect_grant(0);
    req = 4'b0001;
    @(negedge clock);
    req = '0;
    @(negedge clock);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midreset_busy got=%b want=1", busy);
    end
    #2 n_reset = 1'b0;
    #1 check_all_zero("midreset_async");
    dq.delete();
    for (int i = 0; i < R; i++) begin
      mc[i*N +: N] = N'(12 - i);
      mp[i*N +: N] = N'(i + 2);
    end
    for (int i = 0; i < R; i++) expect_req(i);
    req = 4'b1111;
    @(negedge clock);
    n_reset = 1'b1;
    wait_drained("midreset_restart");
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_wrap();
    test_extreme();
    test_stale_ready();
    test_reset_mid();
    repeat (3) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
